// File: rtl/amstrad_pkg.sv
// Shared definitions for the Amstrad MMU configuration-restore sequencer:
// FSM state type, gate-array/ROM-select port addresses and write opcodes.
package amstrad_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        GAP
    } state_t;

    localparam logic [15:0] PORT_GA  = 16'h7F00;
    localparam logic [15:0] PORT_ROM = 16'hDF00;

    localparam logic [1:0] OP_RMR = 2'b10;
    localparam logic [1:0] OP_MMR = 2'b11;

    localparam logic [1:0] IDX_RMR = 2'd0;
    localparam logic [1:0] IDX_MMR = 2'd1;
    localparam logic [1:0] IDX_ROM = 2'd2;

    // RMR carries active-low ROM disables, hence the inversions.
    function automatic logic [7:0] rmr_byte(input logic upper_en,
                                            input logic lower_en,
                                            input logic [1:0] mode);
        return {OP_RMR, 2'b00, ~upper_en, ~lower_en, mode};
    endfunction

endpackage

// File: rtl/restore_timer.sv
// Loadable 4-bit down-counter with zero flag; times the STROBE and GAP phases.
module restore_timer (
    input  logic       CLK,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic       zero
);

    logic [3:0] cnt;

    always_ff @(posedge CLK) begin
        if (reset)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - 4'd1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/amstrad_mmu_restore.sv
// Replays a latched RMR / MMR / ROM-select configuration onto the I/O write bus.
// Optional MMR write enabled by defining MMU_RESTORE_MMR_EN.
module amstrad_mmu_restore
    import amstrad_pkg::*;
#(
    parameter int unsigned WR_HOLD = 2,
    parameter int unsigned WR_GAP  = 2
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        start,
    input  logic        ram64k,
    input  logic        cfg_lower_rom_en,
    input  logic        cfg_upper_rom_en,
    input  logic [1:0]  cfg_mode,
    input  logic [2:0]  cfg_ram_map,
    input  logic [2:0]  cfg_ram_page,
    input  logic [7:0]  cfg_rom_bank,
    output logic        io_WR,
    output logic [15:0] A,
    output logic [7:0]  D,
    output logic        busy,
    output logic        done
);

    localparam logic [3:0] HOLD_LD = 4'(WR_HOLD - 1);
    localparam logic [3:0] GAP_LD  = 4'(WR_GAP - 1);

    state_t     state, state_nx;
    logic [1:0] idx, idx_nx;
    logic       done_nx;
    logic       tmr_load;
    logic [3:0] tmr_val;
    logic       tmr_zero;
    logic       skip_mmr;

    logic       lat_lower, lat_upper;
    logic [1:0] lat_mode;
    logic [7:0] lat_rom;
`ifdef MMU_RESTORE_MMR_EN
    logic       lat_ram64k;
    logic [2:0] lat_map, lat_page;
`else
    logic       unused_cfg;
    assign unused_cfg = ^{ram64k, cfg_ram_map, cfg_ram_page};
`endif

    restore_timer u_timer (
        .CLK      (CLK),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_ff @(posedge CLK) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= IDX_RMR;
            done      <= 1'b0;
            lat_lower <= 1'b0;
            lat_upper <= 1'b0;
            lat_mode  <= '0;
            lat_rom   <= '0;
`ifdef MMU_RESTORE_MMR_EN
            lat_ram64k <= 1'b0;
            lat_map    <= '0;
            lat_page   <= '0;
`endif
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
            done  <= done_nx;
            if (state == IDLE && start) begin
                lat_lower <= cfg_lower_rom_en;
                lat_upper <= cfg_upper_rom_en;
                lat_mode  <= cfg_mode;
                lat_rom   <= cfg_rom_bank;
`ifdef MMU_RESTORE_MMR_EN
                lat_ram64k <= ram64k;
                lat_map    <= cfg_ram_map;
                lat_page   <= cfg_ram_page;
`endif
            end
        end
    end

`ifdef MMU_RESTORE_MMR_EN
    assign skip_mmr = lat_ram64k;
`else
    assign skip_mmr = 1'b1;
`endif

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        done_nx  = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = SETUP;
                    idx_nx   = IDX_RMR;
                end
            end
            SETUP: begin
                state_nx = STROBE;
                tmr_load = 1'b1;
                tmr_val  = HOLD_LD;
            end
            STROBE: begin
                if (tmr_zero) begin
                    state_nx = GAP;
                    tmr_load = 1'b1;
                    tmr_val  = GAP_LD;
                end
            end
            GAP: begin
                if (tmr_zero) begin
                    if (idx == IDX_ROM) begin
                        state_nx = IDLE;
                        idx_nx   = IDX_RMR;
                        done_nx  = 1'b1;
                    end else begin
                        state_nx = SETUP;
                        idx_nx   = (idx == IDX_RMR && !skip_mmr) ? IDX_MMR : IDX_ROM;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Index only moves on SETUP entry, so A/D stay frozen through STROBE and GAP.
    always_comb begin
        A = '0;
        D = '0;
        if (state != IDLE) begin
            case (idx)
                IDX_RMR: begin
                    A = PORT_GA;
                    D = rmr_byte(lat_upper, lat_lower, lat_mode);
                end
`ifdef MMU_RESTORE_MMR_EN
                IDX_MMR: begin
                    A = PORT_GA;
                    D = {OP_MMR, lat_page, lat_map};
                end
`endif
                IDX_ROM: begin
                    A = PORT_ROM;
                    D = lat_rom;
                end
                default: begin
                    A = '0;
                    D = '0;
                end
            endcase
        end
    end

    assign io_WR = (state == STROBE);
    assign busy  = (state != IDLE);

endmodule
